burst_collector_pp: RTL

//  Multi-channel, ping-pong successor to the single-channel burst buffer.
//  - Skips a runtime-programmable number of initial input beats, then packs every M valid beats per channel into a burst.
//  - Bursts are delivered continuously through a valid/ready output slot, with no re-wait between bursts.
//  - Sits between the streaming pixel/feature datapath and the parallel M-wide compute stage.

---
 rtl/burst_pkg.sv | 14 +
 rtl/burst_out_slot.sv | 50 +++++
 rtl/burst_collector_pp.sv | 136 +++++++++++++
 3 files changed

// File: rtl/burst_pkg.sv
// Shared types and helpers for the ping-pong burst collector.
package burst_pkg;

   typedef enum logic [1:0] {
      LATENCY = 2'd0,
      FILL    = 2'd1,
      STALL   = 2'd2
   } state_t;

   function automatic int unsigned clamp_skip(input int unsigned cfg, input int unsigned max_lat);
      return (cfg > max_lat) ? max_lat : cfg;
   endfunction

endpackage

// File: rtl/burst_out_slot.sv
// Valid/ready output register: holds one complete burst and counts accepted bursts.
module burst_out_slot #(
   parameter int unsigned CHANNELS  = 1,
   parameter int unsigned M         = 5,
   parameter int unsigned PRECISION = 5
) (
   input  logic                                        i_clk,
   input  logic                                        i_clr_n,
   input  logic                                        i_ce,
   input  logic                                        i_load,
   input  logic [CHANNELS-1:0][M-1:0][PRECISION-1:0]   i_data,
   input  logic                                        i_ready,
   output logic                                        o_valid,
   output logic [CHANNELS-1:0][M-1:0][PRECISION-1:0]   o_data,
   output logic [15:0]                                 o_count,
   output logic                                        o_slot_free
);

   logic                                        r_valid;
   logic [CHANNELS-1:0][M-1:0][PRECISION-1:0]   r_data;
   logic [15:0]                                 r_count;
   logic                                        w_pop;

   assign w_pop = i_ce & r_valid & i_ready;

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         // A load in the same cycle as a pop keeps the slot occupied with the new burst.
         if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
         if (w_pop) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

   assign o_valid     = r_valid;
   assign o_data      = r_data;
   assign o_count     = r_count;
   assign o_slot_free = ~r_valid | w_pop;

endmodule

// File: rtl/burst_collector_pp.sv
// Multi-channel burst collector: skips an initial run of beats, then packs every M beats
// per channel into a burst handed to a valid/ready output slot without idle cycles.
module burst_collector_pp
   import burst_pkg::*;
#(
   parameter int unsigned CHANNELS        = 1,
   parameter int unsigned M               = 5,
   parameter int unsigned PRECISION       = 5,
   parameter int unsigned MAX_LATENCY     = 15,
   parameter int unsigned LATENCY_DEFAULT = 3,
   localparam int unsigned LW = $clog2(MAX_LATENCY + 1),
   localparam int unsigned CW = $clog2(M + 1)
) (
   input  logic                                        clk,
   input  logic                                        clr_n,
   input  logic                                        ce,
   input  logic                                        start,
   input  logic [LW-1:0]                               latency_cfg,
   input  logic                                        in_valid,
   input  logic [CHANNELS-1:0][PRECISION-1:0]          data_in,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [CHANNELS-1:0][M-1:0][PRECISION-1:0]   data_out,
   output logic [15:0]                                 burst_count,
   output logic                                        overflow
);

   // The counter serves both the skip phase and the fill index, so it spans the wider need.
   localparam int unsigned NW = (LW > CW) ? LW : CW;

   state_t                                      r_state, w_state_d;
   logic [NW-1:0]                               r_count, w_count_d;
   logic [LW-1:0]                               r_skip, w_skip_d;
   logic                                        r_overflow, w_overflow_d;
   logic [CHANNELS-1:0][M-1:0][PRECISION-1:0]   r_fill, w_fill_d;

   logic          w_load;
   logic          w_slot_free;
   logic          w_fill_mode;
   logic          w_last;
   logic [NW-1:0] w_count_inc;
   logic [NW-1:0] w_skip_ext;
   logic [CW-1:0] w_idx;

   assign w_skip_ext  = NW'(r_skip);
   assign w_count_inc = r_count + NW'(1);
   assign w_idx       = r_count[CW-1:0];
   assign w_last      = (r_count == NW'(M - 1));
   // A zero skip lets the very first beat after re-arm be stored.
   assign w_fill_mode = (r_state == FILL) || ((r_state == LATENCY) && (r_count == w_skip_ext));

   always_comb begin
      w_state_d    = r_state;
      w_count_d    = r_count;
      w_skip_d     = r_skip;
      w_overflow_d = r_overflow;
      w_fill_d     = r_fill;
      w_load       = 1'b0;
      if (ce && start) begin
         w_state_d    = LATENCY;
         w_count_d    = '0;
         w_skip_d     = LW'(clamp_skip(32'(latency_cfg), MAX_LATENCY));
         w_overflow_d = 1'b0;
      end else if (ce) begin
         if (w_fill_mode) begin
            w_state_d = FILL;
            if (in_valid) begin
               for (int c = 0; c < CHANNELS; c++) begin
                  w_fill_d[c][w_idx] = data_in[c];
               end
               if (w_last) begin
                  if (w_slot_free) begin
                     w_load    = 1'b1;
                     w_count_d = '0;
                  end else begin
                     w_state_d = STALL;
                  end
               end else begin
                  w_count_d = w_count_inc;
               end
            end
         end else if (r_state == STALL) begin
            if (in_valid) begin
               w_overflow_d = 1'b1;
            end
            if (w_slot_free) begin
               w_load    = 1'b1;
               w_count_d = '0;
               w_state_d = FILL;
            end
         end else if (in_valid) begin
            w_count_d = w_count_inc;
            if (w_count_inc == w_skip_ext) begin
               w_state_d = FILL;
               w_count_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= LATENCY;
         r_count    <= '0;
         r_skip     <= LW'(LATENCY_DEFAULT);
         r_overflow <= 1'b0;
         r_fill     <= '0;
      end else begin
         r_state    <= w_state_d;
         r_count    <= w_count_d;
         r_skip     <= w_skip_d;
         r_overflow <= w_overflow_d;
         r_fill     <= w_fill_d;
      end
   end

   burst_out_slot #(
      .CHANNELS  (CHANNELS),
      .M         (M),
      .PRECISION (PRECISION)
   ) u_slot (
      .i_clk       (clk),
      .i_clr_n     (clr_n),
      .i_ce        (ce),
      .i_load      (w_load),
      .i_data      (w_fill_d),
      .i_ready     (out_ready),
      .o_valid     (out_valid),
      .o_data      (data_out),
      .o_count     (burst_count),
      .o_slot_free (w_slot_free)
   );

   assign overflow = r_overflow;

endmodule
